stopwatch_bcd: RTL and testbench
================================

Name: stopwatch_bcd

Overview:
Upstream feeder for the 4-digit seven-segment display stage. It is a centisecond stopwatch that produces four BCD digits (SS.hh, 00.00 to 99.99) on digit0..digit3. It also produces the free-running refresh strobe that drives the display's enabled input. Start/stop and clear come from raw board buttons; this block synchronises them and detects their edges.

Parameters:
TICK_DIV, 1_000_000, clk cycles per 0.01 s count (100 MHz clock); legal range >= 2
REFRESH_DIV, 100_000, clk cycles per refresh strobe (1 kHz digit scan); legal range >= 2

Ports:
clk  in  1  system clock, single clock domain
rst_n  in  1  asynchronous, active-low reset
btn_start_stop  in  1  raw asynchronous button; each rising edge toggles run state
btn_clear  in  1  raw asynchronous button; each rising edge zeroes the count
digit0  out  4  BCD hundredths of a second
digit1  out  4  BCD tenths of a second
digit2  out  4  BCD seconds units
digit3  out  4  BCD seconds tens
refresh_en  out  1  one-cycle strobe every REFRESH_DIV cycles; goes to the display's enabled input
running  out  1  1 = counting
overflow  out  1  sticky flag: count wrapped 99.99 -> 00.00

Behaviour:
- Reset (async assert, sync release): digits = 0, running = 0, overflow = 0, refresh_en = 0, prescaler = 0, refresh counter = 0, sync/edge flops = 0.
- Button path, per button: 2-flop synchroniser (s1, s2), then a delay flop d.
  - edge = s2 & ~d.
  - An input held high before rising clk edge k gives edge = 1 during the cycle after edge k+1.
  - The resulting state change is visible after edge k+2 (3 cycles of latency).
  - Holding the button high produces exactly one edge. No debounce is done here; bounce yields multiple edges.
- running: toggles on a start_stop edge. No other change except reset.
- Prescaler (0..TICK_DIV-1):
  - Increments only while running = 1.
  - At TICK_DIV-1 it asserts an internal tick for 1 cycle and returns to 0.
  - Stopping holds the prescaler value, so resume continues the partial period.
- Digit chain on tick: digit0 += 1.
  - Each digit at 9 wraps to 0 and carries into the next digit.
  - digit3 at 9 with carry-in wraps to 0 and sets overflow.
  - Digits are always valid BCD (0..9).
- Clear edge:
  - Next cycle: digits = 0, prescaler = 0, overflow = 0.
  - running is unchanged; a running watch restarts from 00.00.
  - Clear has priority over a tick in the same cycle (tick is discarded).
- Clear and start_stop edges in the same cycle: both apply (zero count and toggle running).
- Start_stop edge coinciding with a tick: that tick still counts. The new running value takes effect from the next cycle.
- refresh_en:
  - Free-running counter 0..REFRESH_DIV-1, independent of running and clear.
  - refresh_en = 1 for exactly the cycle in which the counter equals REFRESH_DIV-1. The signal is registered.
  - Period is exactly REFRESH_DIV cycles. The first strobe occurs REFRESH_DIV cycles after reset release.
- Counter widths: $clog2 of each DIV parameter. No truncation is allowed.
- Outputs are all registered. There are no combinational paths from inputs to outputs.

Decomposition:
- Package sseg_pkg holds:
  - typedef bcd_t (logic [3:0]);
  - constants BCD_MAX = 4'd9, NUM_DIGITS = 4;
  - default TICK_DIV and REFRESH_DIV values.
- Sub-module bcd_digit: one cascadable BCD digit.
  - Inputs: clk, rst_n, clr, inc.
  - Outputs: q (bcd_t), carry.
  - carry = inc & (q == 9), combinational.
- stopwatch_bcd instantiates four bcd_digit in a chain and holds the prescaler, refresh counter and button synchronisers inline.

Test Plan (TICK_DIV = 4, REFRESH_DIV = 3):
1. Reset release with no buttons pressed -> digits 0000, running = 0. refresh_en pulses at cycles 3, 6, 9... for 1 cycle each.
2. Pulse btn_start_stop high for 2 cycles -> running = 1 on the 3rd edge after the rise. After 40 further cycles, digits read 00.10 (digit1 = 1, digit0 = 0).
3. Hold btn_start_stop high for 20 cycles -> running toggles exactly once. A second press then stops the count, and the value stays frozen over 100 cycles.
4. Preload by running to 99.98, then 8 more cycles -> 99.99 then 00.00, overflow = 1. A later btn_clear -> 00.00, overflow = 0, running still 1.
5. Assert clear in the same cycle as a tick -> digits 0000, not 0001. Assert start_stop and clear edges together while stopped -> digits 0000, running = 1.
6. Assert rst_n low mid-count for less than 1 clk period, asynchronously -> all outputs 0 immediately. After release, refresh_en is next seen exactly 3 cycles later.

Source files
------------

// File: rtl/sseg_pkg.sv
// Shared types and defaults for the stopwatch / seven-segment display path.
// BCD digit type, digit count and the default divider values for a 100 MHz clock.
package sseg_pkg;
  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX         = 4'd9;
  localparam int   NUM_DIGITS      = 4;
  localparam int   TICK_DIV_DEF    = 1_000_000;
  localparam int   REFRESH_DIV_DEF = 100_000;
endpackage

// File: rtl/bcd_digit.sv
// One cascadable BCD digit: counts 0..9 on inc, wraps and raises a combinational carry.
// Clear wins over increment.
module bcd_digit
  import sseg_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic carry
);
  bcd_t r_q;

  assign q     = r_q;
  assign carry = inc & (r_q == BCD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_q <= '0;
    else if (clr) r_q <= '0;
    else if (inc) r_q <= carry ? '0 : r_q + 4'd1;
  end
endmodule

// File: rtl/stopwatch_bcd.sv
// Centisecond stopwatch (00.00..99.99) feeding the 4-digit display, plus its scan strobe.
// Raw buttons are synchronised here and reduced to single-cycle rising edges.
module stopwatch_bcd
  import sseg_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEF,
  parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_start_stop,
  input  logic btn_clear,
  output bcd_t digit0,
  output bcd_t digit1,
  output bcd_t digit2,
  output bcd_t digit3,
  output logic refresh_en,
  output logic running,
  output logic overflow
);
  localparam int TW = (TICK_DIV > 1)    ? $clog2(TICK_DIV)    : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);

  // Button bit 0 = start/stop, bit 1 = clear.
  logic [1:0] r_s1, r_s2, r_d;
  logic [1:0] w_edge;
  logic       w_ss_edge, w_clr_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_d  <= '0;
    end else begin
      r_s1 <= {btn_clear, btn_start_stop};
      r_s2 <= r_s1;
      r_d  <= r_s2;
    end
  end

  assign w_edge     = r_s2 & ~r_d;
  assign w_ss_edge  = w_edge[0];
  assign w_clr_edge = w_edge[1];

  logic r_running;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_running <= 1'b0;
    else        r_running <= r_running ^ w_ss_edge;
  end

  // Prescaler holds while stopped so a resume finishes the partial period.
  logic [TW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = r_running & (r_presc == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_presc <= '0;
    else if (w_clr_edge) r_presc <= '0;
    else if (w_tick)     r_presc <= '0;
    else if (r_running)  r_presc <= r_presc + TW'(1);
  end

  bcd_t                r_unused_q;
  bcd_t                w_q   [NUM_DIGITS];
  logic [NUM_DIGITS:0] w_inc;

  assign w_inc[0] = w_tick;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
      bcd_digit u_dig (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr_edge),
        .inc   (w_inc[gi]),
        .q     (w_q[gi]),
        .carry (w_inc[gi+1])
      );
    end
  endgenerate

  assign r_unused_q = '0;

  logic r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_overflow <= 1'b0;
    else if (w_clr_edge)        r_overflow <= 1'b0;
    else if (w_inc[NUM_DIGITS]) r_overflow <= 1'b1;
  end

  // Free-running scan strobe, unaffected by run/clear.
  logic [RW-1:0] r_rcnt;
  logic          r_refresh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rcnt    <= '0;
      r_refresh <= 1'b0;
    end else begin
      r_rcnt    <= (r_rcnt == REF_LAST) ? '0 : r_rcnt + RW'(1);
      r_refresh <= (r_rcnt == REF_LAST);
    end
  end

  assign digit0     = w_q[0];
  assign digit1     = w_q[1];
  assign digit2     = w_q[2];
  assign digit3     = w_q[3];
  assign refresh_en = r_refresh;
  assign running    = r_running;
  assign overflow   = r_overflow;
endmodule

// File: tb/tb_stopwatch_bcd.sv
// Self-checking bench for stopwatch_bcd: directed scenarios plus random button activity,
// compared every cycle against an integer-count reference model.
module tb_stopwatch_bcd;
  import sseg_pkg::*;

  localparam int TD = 4;
  localparam int RD = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_start_stop;
  logic btn_clear;
  bcd_t digit0, digit1, digit2, digit3;
  logic refresh_en, running, overflow;

  int checks = 0;
  int errors = 0;

  stopwatch_bcd #(.TICK_DIV(TD), .REFRESH_DIV(RD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_start_stop (btn_start_stop),
    .btn_clear      (btn_clear),
    .digit0         (digit0),
    .digit1         (digit1),
    .digit2         (digit2),
    .digit3         (digit3),
    .refresh_en     (refresh_en),
    .running        (running),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: count is a plain integer of centiseconds.
  int   m_count, m_phase, m_edges;
  bit   m_running, m_ovf;
  bit   m_ss_h1, m_ss_h2, m_ss_h3;
  bit   m_cl_h1, m_cl_h2, m_cl_h3;

  function automatic logic [15:0] to_bcd(input int c);
    return {4'((c / 1000) % 10), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic model_reset();
    m_count = 0; m_phase = 0; m_edges = 0;
    m_running = 0; m_ovf = 0;
    {m_ss_h1, m_ss_h2, m_ss_h3} = '0;
    {m_cl_h1, m_cl_h2, m_cl_h3} = '0;
  endtask

  // A button level sampled at edge n shows up as a press acted on at edge n+2.
  task automatic model_step(input bit ss_in, input bit cl_in);
    bit ss_p, cl_p;
    ss_p = m_ss_h2 & ~m_ss_h3;
    cl_p = m_cl_h2 & ~m_cl_h3;
    if (cl_p) begin
      m_count = 0; m_phase = 0; m_ovf = 0;
    end else if (m_running) begin
      if (m_phase == TD - 1) begin
        m_phase = 0;
        m_count++;
        if (m_count == 10000) begin m_count = 0; m_ovf = 1; end
      end else m_phase++;
    end
    if (ss_p) m_running = ~m_running;
    m_edges++;
    m_ss_h3 = m_ss_h2; m_ss_h2 = m_ss_h1; m_ss_h1 = ss_in;
    m_cl_h3 = m_cl_h2; m_cl_h2 = m_cl_h1; m_cl_h1 = cl_in;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("digits",  {digit3, digit2, digit1, digit0}, to_bcd(m_count));
    chk("running", running, m_running);
    chk("overflow", overflow, m_ovf);
    chk("refresh", refresh_en, (m_edges > 0 && m_edges % RD == 0));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(btn_start_stop, btn_clear);
    #1;
    check_all();
  endtask

  // Raise the chosen buttons for two cycles; the effect is visible on return.
  task automatic press(input bit ss, input bit cl);
    btn_start_stop = ss; btn_clear = cl;
    cyc(); cyc();
    btn_start_stop = 0; btn_clear = 0;
    cyc();
  endtask

  initial begin
    int n;
    int frozen;
    rst_n = 0; btn_start_stop = 0; btn_clear = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1;

    // Idle after reset: strobe every third cycle, nothing counts.
    for (int i = 1; i <= 9; i++) begin
      cyc();
      chk("t1_refresh", refresh_en, (i % 3 == 0));
    end

    // Start, then 40 cycles = 10 ticks.
    press(1, 0);
    chk("t2_running", running, 1);
    repeat (40) cyc();
    chk("t2_digits", {digit3, digit2, digit1, digit0}, 16'h0010);

    // Holding the button toggles exactly once.
    btn_start_stop = 1;
    repeat (20) cyc();
    btn_start_stop = 0;
    repeat (3) cyc();
    chk("t3_hold_once", running, 0);
    press(1, 0);
    chk("t3_restart", running, 1);
    repeat (9) cyc();
    press(1, 0);
    chk("t3_stop", running, 0);
    frozen = m_count;
    repeat (100) cyc();
    chk("t3_frozen", {digit3, digit2, digit1, digit0}, to_bcd(frozen));

    // Random button activity, including bounce-like toggling.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0) btn_start_stop = ~btn_start_stop;
      if ($urandom_range(0, 39) == 0) btn_clear = ~btn_clear;
      cyc();
    end
    btn_start_stop = 0; btn_clear = 0;
    repeat (4) cyc();

    // Run up to 99.98, then through the wrap.
    if (!m_running) press(1, 0);
    chk("t4_running", running, 1);
    n = 0;
    while (m_count != 9998 && n < 60000) begin cyc(); n++; end
    chk("t4_reach_9998", {digit3, digit2, digit1, digit0}, 16'h9998);
    n = 0;
    while (!m_ovf && n < 20) begin cyc(); n++; end
    chk("t4_ovf", overflow, 1);
    chk("t4_wrap", {digit3, digit2, digit1, digit0}, 16'h0000);
    repeat (10) cyc();
    press(0, 1);
    chk("t4_clr_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    chk("t4_clr_ovf", overflow, 0);
    chk("t4_clr_running", running, 1);

    // Clear landing on the same edge as a tick discards the tick.
    repeat (6) cyc();
    n = 0;
    while (m_phase != 1 && n < 20) begin cyc(); n++; end
    btn_clear = 1;
    cyc(); cyc();
    btn_clear = 0;
    cyc();
    chk("t5_clr_vs_tick", {digit3, digit2, digit1, digit0}, 16'h0000);
    press(1, 0);
    chk("t5_stopped", running, 0);
    repeat (5) cyc();
    press(1, 1);
    chk("t5_both_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    chk("t5_both_running", running, 1);
    repeat (30) cyc();

    // Short asynchronous reset pulse mid-count.
    #2 rst_n = 0;
    #1;
    chk("t6_rst_digits", {digit3, digit2, digit1, digit0}, 16'h0000);
    chk("t6_rst_running", running, 0);
    chk("t6_rst_ovf", overflow, 0);
    chk("t6_rst_refresh", refresh_en, 0);
    model_reset();
    #2 rst_n = 1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      chk("t6_refresh", refresh_en, (i % 3 == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
